cnn_layer_seq: RTL and testbench

CNN_LAYER_SEQ -- requirements
Module: cnn_layer_seq

---
 rtl/cnn_layer_seq.sv | 185 ++++++++++++++++++
 tb/tb_cnn_layer_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_seq.sv
// Layer sequencer for the CNN engine: per layer it loads the parameter block,
// runs convolution, optionally pooling, then advances to the next block.
module cnn_layer_seq #(
  parameter int DATA_SIZE  = 16,
  parameter int MEM_SIZE   = 16,
  parameter int PSET_WORDS = 12,
  parameter int TMO_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [7:0]           num_layers,
  input  logic [DATA_SIZE-1:0] MP,
  input  logic                 pset_done,
  input  logic                 conv_done,
  input  logic                 pool_done,
  output logic                 pset_en,
  output logic [MEM_SIZE-1:0]  ps_base,
  output logic                 conv_en,
  output logic                 pool_en,
  output logic [7:0]           layer_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PSET, S_PWAIT, S_CONV, S_POOL, S_NEXT
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          layer_idx_q, layer_idx_d;
  logic [7:0]          count_q, count_d;
  logic [MEM_SIZE-1:0] ps_base_q, ps_base_d;
  logic [TMO_W-1:0]    wdog_q, wdog_d;
  logic                seen_low_q, seen_low_d;
  logic                err_q, err_d;
  logic                pset_en_q, pset_en_d;
  logic                conv_en_q, conv_en_d;
  logic                pool_en_q, pool_en_d;
  logic                done_q, done_d;
  logic                last;
  logic                tmo;
  logic                timed_state;

  always_comb begin
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    count_d     = count_q;
    ps_base_d   = ps_base_q;
    seen_low_d  = seen_low_q;
    err_d       = err_q;
    pset_en_d   = 1'b0;
    conv_en_d   = 1'b0;
    pool_en_d   = 1'b0;
    done_d      = 1'b0;
    wdog_d      = wdog_q;
    last        = ({1'b0, layer_idx_q} + 9'd1) == {1'b0, count_q};
    tmo         = (wdog_q == {TMO_W{1'b1}});
    timed_state = (state_q == S_PWAIT) || (state_q == S_CONV) || (state_q == S_POOL);

    // Pulses are registered on entry to a state, so each is high during the
    // first cycle of that state and never two at once.
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d = 1'b0;
          if (num_layers != 8'd0) begin
            layer_idx_d = 8'd0;
            ps_base_d   = '0;
            count_d     = num_layers;
            state_d     = S_PSET;
            pset_en_d   = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_PSET: begin
        seen_low_d = 1'b0;
        state_d    = S_PWAIT;
      end
      S_PWAIT: begin
        if (!pset_done) seen_low_d = 1'b1;
        if (seen_low_q && pset_done) begin
          state_d   = S_CONV;
          conv_en_d = 1'b1;
        end
      end
      S_CONV: begin
        if (conv_done) begin
          if (|MP) begin
            state_d   = S_POOL;
            pool_en_d = 1'b1;
          end else begin
            state_d = S_NEXT;
            done_d  = last;
          end
        end
      end
      S_POOL: begin
        if (pool_done) begin
          state_d = S_NEXT;
          done_d  = last;
        end
      end
      S_NEXT: begin
        if (last) begin
          state_d = S_IDLE;
        end else begin
          layer_idx_d = layer_idx_q + 8'd1;
          ps_base_d   = ps_base_q + MEM_SIZE'(PSET_WORDS);
          state_d     = S_PSET;
          pset_en_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timed_state && tmo) begin
      state_d   = S_IDLE;
      err_d     = 1'b1;
      conv_en_d = 1'b0;
      pool_en_d = 1'b0;
      done_d    = 1'b0;
    end

    // Abort wins over everything else and leaves err and the layer pointer alone.
    if (abort && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      err_d       = err_q;
      layer_idx_d = layer_idx_q;
      ps_base_d   = ps_base_q;
      pset_en_d   = 1'b0;
      conv_en_d   = 1'b0;
      pool_en_d   = 1'b0;
      done_d      = 1'b0;
    end

    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (timed_state && !tmo) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      layer_idx_q <= 8'd0;
      count_q     <= 8'd0;
      ps_base_q   <= '0;
      wdog_q      <= '0;
      seen_low_q  <= 1'b0;
      err_q       <= 1'b0;
      pset_en_q   <= 1'b0;
      conv_en_q   <= 1'b0;
      pool_en_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      count_q     <= count_d;
      ps_base_q   <= ps_base_d;
      wdog_q      <= wdog_d;
      seen_low_q  <= seen_low_d;
      err_q       <= err_d;
      pset_en_q   <= pset_en_d;
      conv_en_q   <= conv_en_d;
      pool_en_q   <= pool_en_d;
      done_q      <= done_d;
    end
  end

  assign pset_en   = pset_en_q;
  assign conv_en   = conv_en_q;
  assign pool_en   = pool_en_q;
  assign done      = done_q;
  assign err       = err_q;
  assign ps_base   = ps_base_q;
  assign layer_idx = layer_idx_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Directed bench for cnn_layer_seq: multi-layer runs, pooling, empty run,
// watchdog timeout, abort and mid-run reset.
module tb_cnn_layer_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  num_layers;
  logic [15:0] MP;
  logic        pset_done;
  logic        conv_done;
  logic        pool_done;
  logic        pset_en;
  logic [15:0] ps_base;
  logic        conv_en;
  logic        pool_en;
  logic [7:0]  layer_idx;
  logic        busy;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_err = 0;
  int n_pset = 0, n_conv = 0, n_pool = 0, n_done = 0, n_overlap = 0;
  int b_pset, b_conv, b_pool, b_done;
  int wait_cyc;

  cnn_layer_seq #(
    .DATA_SIZE(16), .MEM_SIZE(16), .PSET_WORDS(12), .TMO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_layers(num_layers), .MP(MP), .pset_done(pset_done),
    .conv_done(conv_done), .pool_done(pool_done), .pset_en(pset_en),
    .ps_base(ps_base), .conv_en(conv_en), .pool_en(pool_en),
    .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pset_en) n_pset++;
    if (conv_en) n_conv++;
    if (pool_en) n_pool++;
    if (done) n_done++;
    if ((int'(pset_en) + int'(conv_en) + int'(pool_en) + int'(done)) > 1) n_overlap++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_pset = n_pset;
    b_conv = n_conv;
    b_pool = n_pool;
    b_done = n_done;
  endtask

  // Called in the PSET cycle; ends one cycle after NEXT.
  task automatic run_layer(input bit mp_on, input bit last, input logic [15:0] exp_base,
                           input logic [7:0] exp_idx, input bit poke);
    chk("pset_en_on_entry", 32'(pset_en), 32'd1);
    chk("ps_base", 32'(ps_base), 32'(exp_base));
    chk("layer_idx", 32'(layer_idx), 32'(exp_idx));
    tick();
    pset_done = 1'b0;
    if (poke) begin
      tick();
      start      = 1'b1;
      num_layers = 8'd5;
      tick();
      start      = 1'b0;
      num_layers = 8'd2;
      repeat (10) tick();
    end else begin
      repeat (12) tick();
    end
    pset_done = 1'b1;
    tick();
    chk("conv_en_after_load", 32'(conv_en), 32'd1);
    repeat (19) tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    if (mp_on) begin
      chk("pool_en_after_conv", 32'(pool_en), 32'd1);
      repeat (3) tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      chk("stray_conv_in_pool_busy", 32'(busy), 32'd1);
      chk("stray_conv_in_pool_done", 32'(done), 32'd0);
      repeat (2) tick();
      pool_done = 1'b1;
      tick();
      pool_done = 1'b0;
    end
    chk("done_in_next", 32'(done), 32'(last));
    tick();
    if (last) begin
      chk("busy_after_run", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
    end else begin
      chk("pset_en_next_layer", 32'(pset_en), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_layers = 8'd0; MP = 16'd0;
    pset_done = 1'b1; conv_done = 1'b0; pool_done = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pset_en", 32'(pset_en), 32'd0);
    chk("rst_conv_en", 32'(conv_en), 32'd0);
    chk("rst_pool_en", 32'(pool_en), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ps_base", 32'(ps_base), 32'd0);
    chk("rst_layer_idx", 32'(layer_idx), 32'd0);
    rst = 1'b0;
    tick();

    // Two layers, no pooling, a stray start mid-run.
    snap();
    MP = 16'd0; num_layers = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    run_layer(1'b0, 1'b0, 16'd0, 8'd0, 1'b1);
    run_layer(1'b0, 1'b1, 16'd12, 8'd1, 1'b0);
    chk("a_layer_idx_end", 32'(layer_idx), 32'd1);
    chk("a_pset_count", 32'(n_pset - b_pset), 32'd2);
    chk("a_pool_count", 32'(n_pool - b_pool), 32'd0);
    chk("a_done_count", 32'(n_done - b_done), 32'd1);

    // One layer with pooling.
    snap();
    MP = 16'h0001; num_layers = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run_layer(1'b1, 1'b1, 16'd0, 8'd0, 1'b0);
    chk("b_conv_count", 32'(n_conv - b_conv), 32'd1);
    chk("b_pool_count", 32'(n_pool - b_pool), 32'd1);
    chk("b_done_count", 32'(n_done - b_done), 32'd1);

    // Empty run.
    snap();
    num_layers = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_done", 32'(done), 32'd1);
    chk("c_busy", 32'(busy), 32'd0);
    chk("c_pset_en", 32'(pset_en), 32'd0);
    tick();
    chk("c_done_low", 32'(done), 32'd0);
    chk("c_pset_count", 32'(n_pset - b_pset), 32'd0);

    // Loader never drops pset_done: watchdog expires 257 cycles after PSET.
    snap();
    MP = 16'd0; num_layers = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_pset_en", 32'(pset_en), 32'd1);
    wait_cyc = 0;
    do begin
      tick();
      wait_cyc++;
    end while (busy && wait_cyc < 400);
    chk("d_timeout_cycles", 32'(wait_cyc), 32'd257);
    chk("d_err", 32'(err), 32'd1);
    chk("d_busy", 32'(busy), 32'd0);
    tick();
    chk("d_conv_count", 32'(n_conv - b_conv), 32'd0);
    chk("d_done_count", 32'(n_done - b_done), 32'd0);
    chk("d_err_sticky", 32'(err), 32'd1);
    num_layers = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_err_cleared", 32'(err), 32'd0);
    chk("d_empty_done", 32'(done), 32'd1);
    tick();

    // Abort together with conv_done.
    snap();
    MP = 16'h0001; num_layers = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pset_done = 1'b0;
    repeat (3) tick();
    pset_done = 1'b1;
    tick();
    chk("e_conv_en", 32'(conv_en), 32'd1);
    repeat (4) tick();
    conv_done = 1'b1; abort = 1'b1;
    tick();
    conv_done = 1'b0; abort = 1'b0;
    chk("e_busy", 32'(busy), 32'd0);
    chk("e_pool_en", 32'(pool_en), 32'd0);
    chk("e_done", 32'(done), 32'd0);
    chk("e_err", 32'(err), 32'd0);
    tick();
    chk("e_pool_count", 32'(n_pool - b_pool), 32'd0);
    chk("e_done_count", 32'(n_done - b_done), 32'd0);

    // Reset while pooling on the second layer, then a clean run.
    MP = 16'h0001; num_layers = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    run_layer(1'b1, 1'b0, 16'd0, 8'd0, 1'b0);
    chk("f_ps_base_l1", 32'(ps_base), 32'd12);
    tick();
    pset_done = 1'b0;
    tick();
    pset_done = 1'b1;
    tick();
    chk("f_conv_en", 32'(conv_en), 32'd1);
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    chk("f_pool_en", 32'(pool_en), 32'd1);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("f_rst_busy", 32'(busy), 32'd0);
    chk("f_rst_ps_base", 32'(ps_base), 32'd0);
    chk("f_rst_layer_idx", 32'(layer_idx), 32'd0);
    chk("f_rst_pool_en", 32'(pool_en), 32'd0);
    chk("f_rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    snap();
    MP = 16'd0; num_layers = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    run_layer(1'b0, 1'b1, 16'd0, 8'd0, 1'b0);
    chk("f_done_count", 32'(n_done - b_done), 32'd1);

    chk("pulse_overlap", 32'(n_overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
